// File: rtl/leaf_interface_pkg.sv
// Leaf-interface packet layout shared by the input/output ports.
// Field offsets are derived from the network widths.
package leaf_interface_pkg;

   localparam int LEAF_W    = 6;
   localparam int PORT_W    = 4;
   localparam int ADDR_W    = 7;
   localparam int RSV_W     = 14;
   localparam int PAYLOAD_W = 64;
   localparam int PKT_W     = 1 + LEAF_W + PORT_W + ADDR_W
                            + RSV_W + 1 + PAYLOAD_W;

   localparam int VALID_BIT  = PKT_W - 1;
   localparam int LEAF_LSB   = VALID_BIT - LEAF_W;
   localparam int PORT_LSB   = LEAF_LSB - PORT_W;
   localparam int CREDIT_LSB = PORT_LSB - ADDR_W;
   localparam int TYPE_BIT   = PAYLOAD_W;

   localparam logic TYPE_FREESPACE = 1'b1;

endpackage

// File: rtl/input_port_bram.sv
// Simple dual-port RAM: one write port, one registered read port.
module input_port_bram #(
   parameter int AW = 7,
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      if (rd_en)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/input_port.sv
// Leaf-interface receiver: BRAM ring FIFO, show-ahead user port
// and freespace credit return to the upstream output port.
module input_port
   import leaf_interface_pkg::*;
#(
   parameter int PACKET_BITS           = PKT_W,
   parameter int NUM_LEAF_BITS         = LEAF_W,
   parameter int NUM_PORT_BITS         = PORT_W,
   parameter int NUM_ADDR_BITS         = ADDR_W,
   parameter int PAYLOAD_BITS          = PAYLOAD_W,
   parameter int NUM_BRAM_ADDR_BITS    = 7,
   parameter int FREESPACE_UPDATE_SIZE = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
   input  logic                     wr_en_sel,
   input  logic [NUM_LEAF_BITS-1:0] src_leaf,
   input  logic [NUM_PORT_BITS-1:0] src_port,
   output logic [PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
   output logic                     vld_interface2user,
   input  logic                     ack_user2b_in,
   output logic [PACKET_BITS-1:0]   update_pkt,
   output logic                     update_vld,
   input  logic                     update_ack,
   input  logic                     is_done_mode,
   output logic [PAYLOAD_BITS-1:0]  input_port_full_cnt,
   output logic [PAYLOAD_BITS-1:0]  input_port_empty_cnt,
   output logic                     overflow
);

   localparam int V_BIT = PACKET_BITS - 1;
   localparam int L_LSB = V_BIT - NUM_LEAF_BITS;
   localparam int P_LSB = L_LSB - NUM_PORT_BITS;
   localparam int C_LSB = P_LSB - NUM_ADDR_BITS;
   localparam int T_BIT = PAYLOAD_BITS;
   localparam int AW    = NUM_BRAM_ADDR_BITS;
   localparam int CW    = NUM_ADDR_BITS + 1;

   localparam logic [AW:0]           PTR_ONE  = 1;
   localparam logic [CW-1:0]         UPD_SIZE =
      CW'(FREESPACE_UPDATE_SIZE);
   localparam logic [PAYLOAD_BITS-1:0] CNT_ONE = 1;

   logic [AW:0]              wr_ptr;
   logic [AW:0]              rd_ptr;
   logic [AW:0]              rd_ptr_nxt;
   logic [CW-1:0]            credit_acc;
   logic [PAYLOAD_BITS-1:0]  rd_data;
   logic [PACKET_BITS-1:0]   upd_pkt_nxt;
   logic                     wr_req;
   logic                     wr_do;
   logic                     empty;
   logic                     full;
   logic                     pop;
   logic                     load;
   logic                     latch;
   logic                     unused_din;

   assign wr_req = wr_en_sel & ~is_done_mode
                 & din_leaf_bft2interface[V_BIT];
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW] != rd_ptr[AW])
                 && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign wr_do  = wr_req & ~full;
   assign pop    = vld_interface2user & ack_user2b_in;

   // rd_ptr names the head, so the head still counts toward occupancy
   assign rd_ptr_nxt = pop ? rd_ptr + PTR_ONE : rd_ptr;
   assign load = (~vld_interface2user | pop)
               & (rd_ptr_nxt != wr_ptr);

   assign latch = ~update_vld & (credit_acc >= UPD_SIZE);

   assign unused_din =
      ^din_leaf_bft2interface[V_BIT-1:PAYLOAD_BITS];

   assign dout_leaf_interface2user =
      vld_interface2user ? rd_data : '0;

   input_port_bram #(
      .AW (AW),
      .DW (PAYLOAD_BITS)
   ) u_bram (
      .clk     (clk),
      .wr_en   (wr_do),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (din_leaf_bft2interface[PAYLOAD_BITS-1:0]),
      .rd_en   (load),
      .rd_addr (rd_ptr_nxt[AW-1:0]),
      .rd_data (rd_data)
   );

   always_comb begin
      upd_pkt_nxt = '0;
      upd_pkt_nxt[V_BIT] = 1'b1;
      upd_pkt_nxt[L_LSB +: NUM_LEAF_BITS] = src_leaf;
      upd_pkt_nxt[P_LSB +: NUM_PORT_BITS] = src_port;
      upd_pkt_nxt[C_LSB +: NUM_ADDR_BITS] =
         NUM_ADDR_BITS'(FREESPACE_UPDATE_SIZE);
      upd_pkt_nxt[T_BIT] = TYPE_FREESPACE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         vld_interface2user <= 1'b0;
         overflow           <= 1'b0;
      end else begin
         if (wr_do)
            wr_ptr <= wr_ptr + PTR_ONE;
         rd_ptr <= rd_ptr_nxt;
         vld_interface2user <= load
                             | (vld_interface2user & ~pop);
         if (wr_req & full)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         credit_acc <= '0;
         update_vld <= 1'b0;
         update_pkt <= '0;
      end else begin
         credit_acc <= credit_acc + CW'(pop)
                     - (latch ? UPD_SIZE : '0);
         if (latch) begin
            update_pkt <= upd_pkt_nxt;
            update_vld <= 1'b1;
         end else if (update_ack) begin
            update_vld <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         input_port_full_cnt  <= '0;
         input_port_empty_cnt <= '0;
      end else if (~is_done_mode) begin
         if (full && input_port_full_cnt != '1)
            input_port_full_cnt <= input_port_full_cnt + CNT_ONE;
         if (empty && input_port_empty_cnt != '1)
            input_port_empty_cnt <= input_port_empty_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_input_port.sv
// Directed bench for input_port with a queue-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_input_port;
   import leaf_interface_pkg::*;

   localparam logic [96:0] EXP_UPD =
      {1'b1, 6'd5, 4'd2, 7'd64, 14'd0, 1'b1, 64'd0};

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [96:0] din = '0;
   logic        wr_en_sel = 1'b0;
   logic [5:0]  src_leaf = 6'd5;
   logic [3:0]  src_port = 4'd2;
   logic [63:0] dout;
   logic        vld;
   logic        ack = 1'b0;
   logic [96:0] update_pkt;
   logic        update_vld;
   logic        update_ack = 1'b0;
   logic        is_done_mode = 1'b0;
   logic [63:0] full_cnt;
   logic [63:0] empty_cnt;
   logic        overflow;

   input_port dut (
      .clk                      (clk),
      .reset                    (reset),
      .din_leaf_bft2interface   (din),
      .wr_en_sel                (wr_en_sel),
      .src_leaf                 (src_leaf),
      .src_port                 (src_port),
      .dout_leaf_interface2user (dout),
      .vld_interface2user       (vld),
      .ack_user2b_in            (ack),
      .update_pkt               (update_pkt),
      .update_vld               (update_vld),
      .update_ack               (update_ack),
      .is_done_mode             (is_done_mode),
      .input_port_full_cnt      (full_cnt),
      .input_port_empty_cnt     (empty_cnt),
      .overflow                 (overflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [63:0] d;
      int          w;
   } ent_t;

   ent_t             q[$];
   int               cyc = 0;
   int               last_pop = -10;
   int               m_acc = 0;
   bit               m_uvld = 0;
   bit               m_ov = 0;
   logic [96:0]      m_pkt = '0;
   longint unsigned  m_full = 0;
   longint unsigned  m_empty = 0;
   bit               m_ev;
   bit               m_pop;
   bit               m_wr;
   int               m_sz;

   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         last_pop = -10;
         m_acc = 0;
         m_uvld = 0;
         m_ov = 0;
         m_pkt = '0;
         m_full = 0;
         m_empty = 0;
      end else begin
         // head shows 2 cycles after its write, 1 after prior pop
         m_ev = q.size() > 0 && cyc >= q[0].w + 2
                && cyc >= last_pop + 1;
         chk("vld", vld, m_ev);
         if (m_ev)
            chk("dout", dout, q[0].d);
         chk("update_vld", update_vld, m_uvld);
         if (m_uvld)
            chk("update_pkt", update_pkt, m_pkt);
         chk("full_cnt", full_cnt, m_full);
         chk("empty_cnt", empty_cnt, m_empty);
         chk("overflow", overflow, m_ov);

         m_sz  = q.size();
         m_pop = m_ev && ack;
         m_wr  = wr_en_sel && din[VALID_BIT] && !is_done_mode;
         if (!is_done_mode) begin
            if (m_sz == 128) m_full++;
            if (m_sz == 0)   m_empty++;
         end
         if (m_pop) begin
            void'(q.pop_front());
            last_pop = cyc;
         end
         if (m_wr) begin
            if (m_sz == 128) m_ov = 1;
            else q.push_back('{din[63:0], cyc});
         end
         if (!m_uvld && m_acc >= 64) begin
            m_uvld = 1;
            m_pkt = '0;
            m_pkt[VALID_BIT] = 1'b1;
            m_pkt[LEAF_LSB +: LEAF_W] = src_leaf;
            m_pkt[PORT_LSB +: PORT_W] = src_port;
            m_pkt[CREDIT_LSB +: ADDR_W] = 7'd64;
            m_pkt[TYPE_BIT] = 1'b1;
            m_acc = m_acc + int'(m_pop) - 64;
         end else begin
            m_acc = m_acc + int'(m_pop);
            if (m_uvld && update_ack) m_uvld = 0;
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   logic [63:0] rec[$];

   task automatic step(input bit we, input logic [63:0] d,
                       input bit ak, input bit ua);
      wr_en_sel = we;
      din = '0;
      if (we) begin
         din[VALID_BIT] = 1'b1;
         din[LEAF_LSB +: LEAF_W] = 6'd3;
         din[63:0] = d;
      end
      ack = ak;
      update_ack = ua;
      if (vld && ak)
         rec.push_back(dout);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit chk0);
      #2;
      reset = 1'b1;
      wr_en_sel = 1'b0;
      din = '0;
      ack = 1'b0;
      update_ack = 1'b0;
      is_done_mode = 1'b0;
      #1;
      if (chk0) begin
         chk("rst_vld", vld, 0);
         chk("rst_dout", dout, 0);
         chk("rst_update_vld", update_vld, 0);
         chk("rst_update_pkt", update_pkt, 0);
         chk("rst_full_cnt", full_cnt, 0);
         chk("rst_empty_cnt", empty_cnt, 0);
         chk("rst_overflow", overflow, 0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #1;
      reset = 1'b1;
      #1;
      chk("init_vld", vld, 0);
      chk("init_update_vld", update_vld, 0);
      chk("init_overflow", overflow, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // 3 writes back to back, ack held
      rec.delete();
      step(1, 64'h11, 1, 0);
      chk("t1_vld_n1", vld, 0);
      step(1, 64'h22, 1, 0);
      chk("t1_vld_n2", vld, 1);
      chk("t1_dout0", dout, 64'h11);
      step(1, 64'h33, 1, 0);
      chk("t1_dout1", dout, 64'h22);
      step(0, 0, 1, 0);
      chk("t1_dout2", dout, 64'h33);
      step(0, 0, 1, 0);
      chk("t1_empty", vld, 0);
      step(0, 0, 1, 0);
      chk("t1_cnt", rec.size(), 3);
      for (int k = 0; k < rec.size(); k++)
         chk("t1_data", rec[k], 64'h11 * (k + 1));

      // done mode: writes ignored, counters frozen
      is_done_mode = 1'b1;
      repeat (3) step(1, 64'h44, 1, 0);
      is_done_mode = 1'b0;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("done_no_data", vld, 0);

      // fill to 128 then one extra
      do_reset(0);
      for (int i = 0; i < 128; i++)
         step(1, 64'h1000 + i, 0, 0);
      step(1, 64'hdead, 0, 0);
      chk("t2_overflow", overflow, 1);
      chk("t2_full_cnt", full_cnt, 1);
      rec.delete();
      repeat (135) step(0, 0, 1, 0);
      chk("t2_cnt", rec.size(), 128);
      begin
         int bad = 0;
         for (int k = 0; k < rec.size(); k++)
            if (rec[k] !== 64'h1000 + k) bad++;
         chk("t2_order", bad, 0);
      end

      // 64 reads -> one credit update, held until ack
      do_reset(0);
      for (int i = 0; i < 64; i++)
         step(1, 64'h2000 + i, 1, 0);
      repeat (4) step(0, 0, 1, 0);
      for (int i = 0; i < 10; i++) begin
         chk("t3_upd_vld", update_vld, 1);
         chk("t3_upd_pkt", update_pkt, EXP_UPD);
         step(0, 0, 0, 0);
      end
      step(0, 0, 0, 1);
      chk("t3_upd_drop", update_vld, 0);

      // 130 reads, second update only after first is acked
      do_reset(0);
      for (int i = 0; i < 130; i++)
         step(1, 64'h3000 + i, 1, 0);
      repeat (4) step(0, 0, 1, 0);
      chk("t4_pending", update_vld, 1);
      step(0, 0, 0, 1);
      chk("t4_drop", update_vld, 0);
      step(0, 0, 0, 0);
      chk("t4_second", update_vld, 1);
      chk("t4_second_pkt", update_pkt, EXP_UPD);
      chk("t4_model_acc", m_acc, 2);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      chk("t4_idle", update_vld, 0);

      // write+ack at occupancy 1 across the 127->0 wrap
      do_reset(0);
      rec.delete();
      step(1, 64'h4000, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 1; i <= 130; i++) begin
         step(1, 64'h4000 + i, 1, 0);
         step(0, 0, 1, 0);
      end
      repeat (3) step(0, 0, 1, 0);
      chk("t5_cnt", rec.size(), 131);
      begin
         int bad = 0;
         for (int k = 0; k < rec.size(); k++)
            if (rec[k] !== 64'h4000 + k) bad++;
         chk("t5_order", bad, 0);
      end

      // reset with 5 queued and an update pending
      do_reset(0);
      for (int i = 0; i < 64; i++)
         step(1, 64'h5000 + i, 1, 0);
      repeat (4) step(0, 0, 1, 0);
      for (int i = 0; i < 5; i++)
         step(1, 64'h6000 + i, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("t6_pre_vld", vld, 1);
      chk("t6_pre_upd", update_vld, 1);
      do_reset(1);
      chk("t6_empty_cnt0", empty_cnt, 0);
      repeat (3) step(0, 0, 0, 0);
      chk("t6_empty_cnt3", empty_cnt, 3);
      chk("t6_vld", vld, 0);
      chk("t6_upd", update_vld, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/input_port.md
Name: input_port

Overview:
- Receiving end of the leaf-interface packet protocol whose transmitting end is the output port.
- Accepts packets routed to this leaf/port from the BFT switch and buffers their payloads in a BRAM ring FIFO.
- Presents payloads to the user with a valid/ack handshake.
- Returns freespace credits to the sending output port as update packets, so the sender never overruns the FIFO.

Parameters:
- PACKET_BITS, 97, network packet width.
- NUM_LEAF_BITS, 6, leaf address width.
- NUM_PORT_BITS, 4, port address width.
- NUM_ADDR_BITS, 7, freespace/credit field width.
- PAYLOAD_BITS, 64, user data width.
- NUM_BRAM_ADDR_BITS, 7, FIFO depth = 2^NUM_BRAM_ADDR_BITS (128).
- FREESPACE_UPDATE_SIZE, 64, number of user reads that triggers a credit update.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high.
- din_leaf_bft2interface  in  PACKET_BITS  packet from switch.
- wr_en_sel  in  1  packet on din is addressed to this port.
- src_leaf  in  NUM_LEAF_BITS  leaf of the upstream output port (config reg).
- src_port  in  NUM_PORT_BITS  port of the upstream output port (config reg).
- dout_leaf_interface2user  out  PAYLOAD_BITS  head payload.
- vld_interface2user  out  1  head payload valid.
- ack_user2b_in  in  1  user consumes head.
- update_pkt  out  PACKET_BITS  credit update packet.
- update_vld  out  1  update packet pending.
- update_ack  in  1  arbiter took update_pkt this cycle.
- is_done_mode  in  1  freeze counters, stop accepting new data.
- input_port_full_cnt  out  PAYLOAD_BITS  cycles spent full.
- input_port_empty_cnt  out  PAYLOAD_BITS  cycles spent empty.
- overflow  out  1  sticky; a write arrived while full.

Behaviour:
- Packet layout:
  - [96] valid
  - [95:90] dst_leaf
  - [89:86] dst_port
  - [85:79] credit/fifo field
  - [78:65] reserved, 0
  - [64] type (1 = freespace update)
  - [63:0] payload
  - All offsets are derived from the parameters.
- Reset values: all outputs 0; pointers 0; credit accumulator 0.
- Write path:
  - Accept when wr_en_sel & din[valid] & !is_done_mode.
  - Payload is written at wr_ptr and wr_ptr increments, wrapping modulo depth.
  - Occupancy is tracked with an extra wrap bit on each pointer: full when the pointers are equal with differing wrap bits.
- Write while full: the data is dropped, the pointers are unchanged and overflow sets until reset.
- Read path:
  - Show-ahead: BRAM read latency 1 plus an output register.
  - A payload written at cycle N into an empty FIFO gives vld_interface2user=1 at N+2.
- User handshake:
  - Head transfers when vld & ack; the next entry is presented the following cycle with no bubble when the FIFO is non-empty.
  - ack while !vld is ignored.
  - dout is held stable while vld & !ack.
- Simultaneous write and read at count 1: the new entry follows the head with no loss and no duplicate.
- Credits:
  - Each user transfer increments credit_acc (NUM_ADDR_BITS+1 bits).
  - When credit_acc >= FREESPACE_UPDATE_SIZE and no update is pending, latch update_pkt: valid=1, dst=src_leaf/src_port, type=1, credit field = FREESPACE_UPDATE_SIZE. Then raise update_vld and subtract FREESPACE_UPDATE_SIZE from credit_acc in the same cycle.
  - update_vld holds with update_pkt stable until update_ack, and drops the cycle after.
  - Reads continue to accumulate while an update is pending.
  - A read and a latch in the same cycle yield credit_acc = credit_acc + 1 - FREESPACE_UPDATE_SIZE.
- Counters:
  - full_cnt increments each cycle the FIFO is full; empty_cnt increments each cycle it is empty.
  - Both freeze while is_done_mode=1 and saturate at all-ones.
- Reset mid-operation: FIFO contents are abandoned, pointers return to 0, and any pending update is discarded with update_vld=0 immediately.

Decomposition:
- Shared package (leaf_interface_pkg):
  - packet field offsets (VALID_BIT, LEAF_LSB, PORT_LSB, CREDIT_LSB, TYPE_BIT);
  - TYPE_FREESPACE constant;
  - the derived localparam for the packet width.
- Sub-module input_port_bram: simple dual-port RAM, 1 write and 1 registered read, depth 2^NUM_BRAM_ADDR_BITS, width PAYLOAD_BITS, inferred as block RAM.

Test Plan:
- Write 3 packets with payloads 0x11,0x22,0x33 at cycles 10,11,12, ack held high -> vld rises at cycle 12; dout is 0x11,0x22,0x33 on consecutive cycles; empty afterwards.
- Write 128 packets with no ack, then one more -> full_cnt increments; the 129th is dropped and overflow=1. Then read all -> exactly 128 payloads, in order.
- With src_leaf=5, src_port=2, perform 64 user reads -> update_vld=1 with dst_leaf=5, dst_port=2, type=1, credit=64. Hold update_ack=0 for 10 cycles -> packet stays stable; ack -> update_vld=0 next cycle.
- Perform 130 reads with update_ack tied to 0 after the first update -> a single update is pending; after ack, a second update issues; credit_acc ends at 2.
- Write and ack in the same cycle at occupancy 1 across the pointer wrap at address 127→0 -> no loss or duplication; payload order preserved.
- Assert reset while 5 entries are queued and an update is pending -> all outputs 0 asynchronously; after release, the FIFO is empty and empty_cnt counts from 0.
